tl_sram_slave: RTL
==================

# tl_sram_slave

Parametrised TileLink-UL/UH SRAM slave for the on-chip interconnect. Data width and depth are configurable, and multi-beat bursts are supported for Get and Put. Atomics are lane-correct, signed and unsigned, with explicit denial of illegal requests. After reset the block zeroes its storage before accepting traffic. It sits behind the crossbar as a single-outstanding-transaction target.

## Interface
- TL_DW, 32: data width in bits (32 or 64); LG = log2(TL_DW/8).
- TL_AW, 12: byte-address width; depth = 2^(TL_AW-LG) words.
- TL_RS, 4: source-ID width.
- MAX_SIZE, 6: largest legal lg2 transfer size (≤12).
- ATOMICS, 1: 1 enables Arithmetic/LogicalData; 0 denies them.
- sram_clock_i  in  1  clock; everything on rising edge.
- sram_reset_i  in  1  reset, asynchronous, active-low.
- sram_a_opcode/param/size/source/address/mask/data/corrupt/valid  in  3/3/4/TL_RS/TL_AW/TL_DW/8/TL_DW/1/1  TL A channel; corrupt is ignored.
- sram_a_ready  out  1  A accept.
- sram_d_opcode/param/size/source/denied/data/corrupt/valid  out  3/2/4/TL_RS/1/TL_DW/1/1  TL D channel.
- sram_d_ready  in  1  D accept.

## Operation
- **Reset values.** While reset is low, all outputs are 0 (a_ready=0, d_valid=0), state=CLEAR and the sweep counter is 0.
- **CLEAR.** Writes all-zero to word `cnt`, incrementing each cycle. After the last word (depth cycles) the block goes to IDLE. a_ready=0 throughout.
- **IDLE.** a_ready=1 only when d_valid=0 or d_ready=1. A beat is accepted on a_valid&a_ready.
- **Word index.** index = address[TL_AW-1:LG] + beat. Bursts are size-aligned, so there is no wrap.
- **Beat count.** beats = size>LG ? 2^(size-LG) : 1.
- **Denial checks.**
  - An access is denied when size>MAX_SIZE, the param is illegal, or it is an atomic with ATOMICS=0.
  - An atomic with size>LG is also denied.
  - Illegal params: Arithmetic param>4, Logical param>3.
- **Get.** Reads one word per beat and returns AccessAckData (opcode 1) with lane-aligned data. There is no sub-word shifting; data appears on the byte lanes selected by the address.
  - State READ issues beats until the count expires; a beat advances only on d_ready.
- **PutFull/PutPartial.** Each beat writes its mask bytes. State WRITE accepts the remaining beats.
  - After the last beat, a single AccessAck (opcode 0) is sent.
- **Atomics.** State ATOMIC runs read, then modify/write, then respond. The response is AccessAckData carrying the old word.
  - Operand: 8<<size bits at byte offset address[LG-1:0]. Unselected lanes are written back unchanged.
  - Arithmetic: 0 MIN (signed), 1 MAX (signed), 2 MINU, 3 MAXU, 4 ADD (carry confined to operand).
  - Logical: 0 XOR, 1 OR, 2 AND, 3 SWAP.
- **Denied requests.**
  - Storage is never written.
  - Put beats are drained and acknowledged once.
  - Get/atomic return beats with data=0.
  - All denied responses carry denied=1; Get/atomic responses also carry corrupt=1.
- **D-channel fields.** d_size and d_source echo the request; d_param=0.
- **Reset mid-operation.** The transaction is abandoned, d_valid drops asynchronously, and CLEAR restarts.

## Timing
- A single-beat Get accepted at edge N gives d_valid high after N+1, holding the read data.
- Get bursts deliver one beat per cycle while d_ready=1. When d_ready=0, d_valid and data hold stable.
- A Put beat is written at its accept edge. The Ack is valid one cycle after the last beat is accepted.
- Atomic accepted at N:
  - read registered at N+1;
  - memory written at the N+1 edge;
  - d_valid after N+2.
- A new request is accepted no earlier than the cycle its predecessor's last D beat handshakes. Back-to-back single-beat Gets sustain 1 per cycle.
- A read in the same cycle as a write to the same word returns the old data. This cannot happen externally, since there is one outstanding transaction.
- CLEAR takes exactly depth cycles after reset deasserts. The first a_ready is at cycle depth+1.

## Test plan
- **Reset sweep.** Release reset with TL_AW=12, TL_DW=32.
  - a_ready=0 for 1024 cycles.
  - A Get of address 0x3FC then returns d_data=0, opcode 1, denied 0.
- **PutPartial/Get.** PutPartial at 0x10, mask 0b0110, data 0xAABBCCDD over a word holding 0x11223344.
  - AccessAck follows.
  - A Get of 0x10 with size 2 returns 0x11BBCC44.
- **Burst with backpressure.** PutFull size 4 at 0x40, beats 1,2,3,4, then Get size 4 with d_ready toggling 1,0,1,0.
  - Beats come back 1,2,3,4 in order, each held while d_ready=0.
  - d_source matches the request.
- **Atomics.**
  - ArithmeticData MIN, size 2, at a word holding 0x00000005, data 0xFFFFFFFE: d_data=5 and the word becomes 0xFFFFFFFE.
  - MINU with the same values leaves the word at 5.
  - ADD, size 0, at byte 1 of 0x0000FF00 with data 0x00000200: the word becomes 0x00000100 (no carry out of the byte).
- **Denied requests.**
  - Get with size 7 when MAX_SIZE=6: 32 beats, each with denied=1, corrupt=1, data=0.
  - Arithmetic with param 6: one beat, denied=1, memory unchanged.
- **Mid-burst reset.** Assert reset during beat 2 of a 16-beat Get.
  - d_valid goes to 0 immediately.
  - After release, the block performs CLEAR; all words read 0.

Source files
------------

// File: rtl/tl_sram_slave.sv
// tl_sram_slave: TileLink-UL/UH SRAM target with Get/Put bursts, lane-correct atomics and a zeroing sweep after reset.
module tl_sram_slave #(
    parameter int TL_DW    = 32,
    parameter int TL_AW    = 12,
    parameter int TL_RS    = 4,
    parameter int MAX_SIZE = 6,
    parameter int ATOMICS  = 1
) (
    input  logic               sram_clock_i,
    input  logic               sram_reset_i,
    input  logic [2:0]         sram_a_opcode,
    input  logic [2:0]         sram_a_param,
    input  logic [3:0]         sram_a_size,
    input  logic [TL_RS-1:0]   sram_a_source,
    input  logic [TL_AW-1:0]   sram_a_address,
    input  logic [TL_DW/8-1:0] sram_a_mask,
    input  logic [TL_DW-1:0]   sram_a_data,
    input  logic               sram_a_corrupt,
    input  logic               sram_a_valid,
    output logic               sram_a_ready,
    output logic [2:0]         sram_d_opcode,
    output logic [1:0]         sram_d_param,
    output logic [3:0]         sram_d_size,
    output logic [TL_RS-1:0]   sram_d_source,
    output logic               sram_d_denied,
    output logic [TL_DW-1:0]   sram_d_data,
    output logic               sram_d_corrupt,
    output logic               sram_d_valid,
    input  logic               sram_d_ready
);
    localparam int LG = $clog2(TL_DW / 8);
    localparam int WA = TL_AW - LG;
    localparam logic [3:0] LG4 = 4'(LG);
    localparam logic [3:0] MS4 = 4'(MAX_SIZE);

    typedef enum logic [2:0] {CLEAR, IDLE, READ, WRITE, ATOMIC} state_e;

    state_e state_q, state_d;
    logic [TL_DW-1:0] mem [2**WA];
    logic [WA-1:0] cnt_q, cnt_d, idx_q, idx_d, a_idx, waddr;
    logic [15:0] rem_q, rem_d, tot_q, tot_d, a_beats;
    logic [2:0] op_q, op_d, prm_q, prm_d, d_opcode_q, d_opcode_d;
    logic [3:0] size_q, size_d;
    logic [TL_RS-1:0] src_q, src_d;
    logic [LG-1:0] off_q, off_d;
    logic [TL_DW-1:0] adata_q, adata_d, d_data_q, d_data_d, wdata, old, a_al, b_al, r_al, lane, amo;
    logic [TL_DW/8-1:0] wmask;
    logic den_q, den_d, ph_q, ph_d, d_valid_q, d_valid_d, d_den_q, d_den_d, d_cor_q, d_cor_d;
    logic we, a_den, acc, is_amo, lt_s, lt_u, unused_ok;
    int w, osh, ash;

    assign a_idx = sram_a_address[TL_AW-1:LG];
    assign a_beats = sram_a_size > LG4 ? 16'd1 << (sram_a_size - LG4) : 16'd1;
    assign is_amo = sram_a_opcode == 3'd2 || sram_a_opcode == 3'd3;
    assign a_den = sram_a_size > MS4 || sram_a_opcode > 3'd4
                 || (sram_a_opcode == 3'd2 && sram_a_param > 3'd4)
                 || (sram_a_opcode == 3'd3 && sram_a_param > 3'd3)
                 || (is_amo && (ATOMICS == 0 || sram_a_size > LG4));
    assign sram_a_ready = (state_q == IDLE && (!d_valid_q || sram_d_ready)) || state_q == WRITE;
    assign acc = sram_a_valid && sram_a_ready;
    assign old = mem[idx_q];
    assign unused_ok = sram_a_corrupt;

    // Operands are shifted up to the MSB so signed compares and carry-confined adds work at any size
    always_comb begin
        w = 8 << size_q;
        osh = 8 * int'(off_q);
        ash = TL_DW - w;
        a_al = (old >> osh) << ash;
        b_al = (adata_q >> osh) << ash;
        lt_s = $signed(a_al) < $signed(b_al);
        lt_u = a_al < b_al;
        r_al = op_q == 3'd3
             ? (prm_q == 3'd0 ? a_al ^ b_al : prm_q == 3'd1 ? a_al | b_al : prm_q == 3'd2 ? a_al & b_al : b_al)
             : (prm_q == 3'd0 ? (lt_s ? a_al : b_al) : prm_q == 3'd1 ? (lt_s ? b_al : a_al)
             : prm_q == 3'd2 ? (lt_u ? a_al : b_al) : prm_q == 3'd3 ? (lt_u ? b_al : a_al) : a_al + b_al);
        lane = ({TL_DW{1'b1}} >> ash) << osh;
        amo = (old & ~lane) | (((r_al >> ash) << osh) & lane);
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        rem_d = rem_q;
        tot_d = tot_q;
        op_d = op_q;
        prm_d = prm_q;
        size_d = size_q;
        src_d = src_q;
        off_d = off_q;
        adata_d = adata_q;
        den_d = den_q;
        ph_d = ph_q;
        d_valid_d = d_valid_q && !sram_d_ready;
        d_opcode_d = d_opcode_q;
        d_data_d = d_data_q;
        d_den_d = d_den_q;
        d_cor_d = d_cor_q;
        we = 1'b0;
        waddr = a_idx;
        wdata = sram_a_data;
        wmask = sram_a_mask;
        case (state_q)
            CLEAR: begin
                we = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                wmask = '1;
                cnt_d = cnt_q + WA'(1);
                if (&cnt_q) state_d = IDLE;
            end
            IDLE: if (acc) begin
                op_d = sram_a_opcode;
                prm_d = sram_a_param;
                size_d = sram_a_size;
                src_d = sram_a_source;
                off_d = sram_a_address[LG-1:0];
                adata_d = sram_a_data;
                den_d = a_den;
                idx_d = a_idx + WA'(1);
                rem_d = a_beats - 16'd1;
                tot_d = a_beats;
                if (sram_a_opcode < 3'd2) begin
                    we = !a_den;
                    d_valid_d = a_beats == 16'd1;
                    d_opcode_d = 3'd0;
                    d_data_d = '0;
                    d_den_d = a_den;
                    d_cor_d = 1'b0;
                    if (a_beats != 16'd1) state_d = WRITE;
                end else if (is_amo) begin
                    idx_d = a_idx;
                    state_d = a_beats == 16'd1 ? ATOMIC : WRITE;
                end else begin
                    d_valid_d = 1'b1;
                    d_opcode_d = 3'd1;
                    d_data_d = a_den ? '0 : mem[a_idx];
                    d_den_d = a_den;
                    d_cor_d = a_den;
                    if (a_beats != 16'd1) state_d = READ;
                end
            end
            READ: if (sram_d_ready) begin
                d_valid_d = 1'b1;
                d_data_d = den_q ? '0 : mem[idx_q];
                idx_d = idx_q + WA'(1);
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) state_d = IDLE;
            end
            // Multi-beat atomics only land here denied: their data beats are drained, then zero beats returned
            WRITE: if (acc) begin
                we = !den_q;
                waddr = idx_q;
                idx_d = idx_q + WA'(1);
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) begin
                    d_valid_d = 1'b1;
                    d_opcode_d = {2'b0, op_q[1]};
                    d_data_d = '0;
                    d_den_d = den_q;
                    d_cor_d = op_q[1];
                    rem_d = tot_q - 16'd1;
                    state_d = op_q[1] ? READ : IDLE;
                end
            end
            ATOMIC: begin
                ph_d = !ph_q;
                if (!ph_q) begin
                    we = !den_q;
                    waddr = idx_q;
                    wdata = amo;
                    wmask = '1;
                    d_data_d = den_q ? '0 : old;
                end else begin
                    d_valid_d = 1'b1;
                    d_opcode_d = 3'd1;
                    d_den_d = den_q;
                    d_cor_d = den_q;
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge sram_clock_i or negedge sram_reset_i) begin
        if (!sram_reset_i) begin
            state_q <= CLEAR;
            cnt_q <= '0;
            idx_q <= '0;
            rem_q <= '0;
            tot_q <= '0;
            op_q <= '0;
            prm_q <= '0;
            size_q <= '0;
            src_q <= '0;
            off_q <= '0;
            adata_q <= '0;
            den_q <= 1'b0;
            ph_q <= 1'b0;
            d_valid_q <= 1'b0;
            d_opcode_q <= '0;
            d_data_q <= '0;
            d_den_q <= 1'b0;
            d_cor_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            rem_q <= rem_d;
            tot_q <= tot_d;
            op_q <= op_d;
            prm_q <= prm_d;
            size_q <= size_d;
            src_q <= src_d;
            off_q <= off_d;
            adata_q <= adata_d;
            den_q <= den_d;
            ph_q <= ph_d;
            d_valid_q <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_data_q <= d_data_d;
            d_den_q <= d_den_d;
            d_cor_q <= d_cor_d;
        end
    end

    always_ff @(posedge sram_clock_i) begin
        if (we)
            for (int i = 0; i < TL_DW / 8; i++)
                if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign sram_d_valid = d_valid_q;
    assign sram_d_opcode = d_opcode_q;
    assign sram_d_param = '0;
    assign sram_d_size = size_q;
    assign sram_d_source = src_q;
    assign sram_d_denied = d_den_q;
    assign sram_d_data = d_data_q;
    assign sram_d_corrupt = d_cor_q;
endmodule
